sevenseg_scan_n: RTL and testbench

SEVENSEG_SCAN_N -- requirements
Module: sevenseg_scan_n

---
 rtl/sevenseg_scan_n.sv | 153 +++++++++++++++
 tb/tb_sevenseg_scan_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with shadowed digit codes,
// leading-zero suppression, per-digit blink and a one-cycle anode ghost guard.
module sevenseg_scan_n #(
    parameter int NDIG        = 8,
    parameter int DIV         = 100000,
    parameter int BLINK_SCANS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7*NDIG-1:0]   d,
    input  logic                load,
    input  logic [NDIG-1:0]     blink_en,
    input  logic                lz_en,
    output logic [NDIG-1:0]     an_n,
    output logic [6:0]          segs_n,
    output logic                dp_n,
    output logic                scan_done
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = $clog2(DIV);
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [PW-1:0]   pre_reg;
    logic [IW-1:0]   idx_reg;
    logic [BW-1:0]   bcnt_reg;
    logic            phase_reg;
    logic [6:0]      code_reg [NDIG];
    logic [NDIG-1:0] blink_reg;
    logic            lz_reg;

    logic            tick;
    logic            wrap;
    logic [6:0]      cur_code;
    logic [NDIG-1:0] lz_mask;
    logic            run_zero;
    logic            blank;
    logic [NDIG-1:0] an_next;
    logic [6:0]      segs_next;
    logic            dp_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick = (pre_reg == PW'(DIV - 1));
    assign wrap = tick && (idx_reg == IW'(NDIG - 1));

    // Timebase: prescaler, digit index and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg   <= '0;
            idx_reg   <= '0;
            bcnt_reg  <= '0;
            phase_reg <= 1'b0;
        end else begin
            pre_reg <= tick ? '0 : pre_reg + 1'b1;
            if (wrap) begin
                idx_reg <= '0;
                if (bcnt_reg == BW'(BLINK_SCANS - 1)) begin
                    bcnt_reg  <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    bcnt_reg <= bcnt_reg + 1'b1;
                end
            end else if (tick) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_reg[gi] <= 7'h40;
                end else if (load) begin
                    code_reg[gi] <= d[7*gi +: 7];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_reg <= '0;
            lz_reg    <= 1'b0;
        end else if (load) begin
            blink_reg <= blink_en;
            lz_reg    <= lz_en;
        end
    end

    // A digit is a leading zero when it and every digit above it are 0x00.
    always_comb begin
        lz_mask  = '0;
        run_zero = lz_reg;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run_zero   = run_zero & (code_reg[i] == 7'h00);
            lz_mask[i] = run_zero;
        end
        lz_mask[0] = 1'b0;
    end

    always_comb begin
        cur_code  = code_reg[idx_reg];
        blank     = cur_code[6] | lz_mask[idx_reg] | (phase_reg & blink_reg[idx_reg]);
        segs_next = hex7(cur_code[3:0]);
        if (blank) begin
            segs_next = 7'h7F;
        end else if (cur_code[4]) begin
            segs_next = 7'b0111111;
        end
        dp_next = blank | ~cur_code[5];
        an_next = '1;
        // Prescaler at zero marks the first cycle of a slot: keep all anodes off.
        if (pre_reg != '0) begin
            an_next[idx_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n      <= '1;
            segs_n    <= 7'h7F;
            dp_n      <= 1'b1;
            scan_done <= 1'b0;
        end else begin
            an_n      <= an_next;
            segs_n    <= segs_next;
            dp_n      <= dp_next;
            scan_done <= wrap;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Scoreboard bench for sevenseg_scan_n: a cycle-count reference model predicts
// each registered output word; a negedge monitor pops and compares.
module tb_sevenseg_scan_n;

    localparam int NDIG = 4;
    localparam int DIV  = 4;
    localparam int BS   = 2;
    localparam int SCAN = DIV * NDIG;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7*NDIG-1:0]   d = '0;
    logic                load = 1'b0;
    logic [NDIG-1:0]     blink_en = '0;
    logic                lz_en = 1'b0;
    logic [NDIG-1:0]     an_n;
    logic [6:0]          segs_n;
    logic                dp_n;
    logic                scan_done;

    sevenseg_scan_n #(.NDIG(NDIG), .DIV(DIV), .BLINK_SCANS(BS)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .load(load), .blink_en(blink_en),
        .lz_en(lz_en), .an_n(an_n), .segs_n(segs_n), .dp_n(dp_n),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NDIG-1:0] an;
        logic [6:0]      segs;
        logic            dp;
        logic            sd;
    } exp_t;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              m = 0;
    logic [6:0]      sh_code [NDIG];
    logic [NDIG-1:0] sh_blink;
    logic            sh_lz;
    logic [6:0]      hex_tab [16];

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < NDIG; i++) sh_code[i] = 7'h40;
        sh_blink = '0;
        sh_lz    = 1'b0;
    end

    function automatic exp_t reset_word();
        exp_t e;
        e.an = '1; e.segs = 7'h7F; e.dp = 1'b1; e.sd = 1'b0;
        return e;
    endfunction

    // Output word produced from the state "mm clocks after reset release".
    function automatic exp_t predict(int mm);
        exp_t e;
        int   digit = (mm / DIV) % NDIG;
        int   phase = ((mm / SCAN) / BS) % 2;
        logic [6:0] code = sh_code[digit];
        logic lzb = 1'b0;
        logic blank;
        if (sh_lz && digit != 0) begin
            lzb = 1'b1;
            for (int j = digit; j < NDIG; j++)
                if (sh_code[j] != 7'h00) lzb = 1'b0;
        end
        blank = code[6] || lzb || (phase == 1 && sh_blink[digit]);
        e.an = '1;
        if (mm % DIV != 0) e.an[digit] = 1'b0;
        if (blank)        e.segs = 7'h7F;
        else if (code[4]) e.segs = 7'b0111111;
        else              e.segs = hex_tab[code[3:0]];
        e.dp = blank ? 1'b1 : ~code[5];
        e.sd = (mm % SCAN) == SCAN - 1;
        return e;
    endfunction

    // Reference model: one expected word per clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.push_back(reset_word());
            m = 0;
            for (int i = 0; i < NDIG; i++) sh_code[i] = 7'h40;
            sh_blink = '0;
            sh_lz    = 1'b0;
        end else begin
            exp_q.push_back(predict(m));
            if (load) begin
                for (int i = 0; i < NDIG; i++) sh_code[i] = d[7*i +: 7];
                sh_blink = blink_en;
                sh_lz    = lz_en;
            end
            m = m + 1;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: no expected word queued", $time);
        end else begin
            e = exp_q.pop_front();
            if ({an_n, segs_n, dp_n, scan_done} !== e) begin
                n_fail++;
                $display("FAIL outputs at %0t: got an_n=%b segs_n=%b dp_n=%b scan_done=%b, expected an_n=%b segs_n=%b dp_n=%b scan_done=%b",
                         $time, an_n, segs_n, dp_n, scan_done, e.an, e.segs, e.dp, e.sd);
            end
        end
    end

    task automatic do_load(input logic [7*NDIG-1:0] dv, input logic [NDIG-1:0] bv, input logic lv);
        d = dv; blink_en = bv; lz_en = lv; load = 1'b1;
        $display("load d=%h blink_en=%b lz_en=%b at state %0d", dv, bv, lv, m);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the next edge consumes state with given slot position.
    task automatic wait_pos(input int digit, input int cnt, input string name);
        int budget = 200;
        while (!(((m / DIV) % NDIG) == digit && (m % DIV) == cnt) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_fail++;
            $display("FAIL %s: position digit=%0d cnt=%0d not reached, state=%0d", name, digit, cnt, m);
        end
    endtask

    task automatic async_reset_check(input string name);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({an_n, segs_n, dp_n, scan_done} !== reset_word()) begin
            n_fail++;
            $display("FAIL %s: got an_n=%b segs_n=%b dp_n=%b scan_done=%b, expected all-high/blank",
                     name, an_n, segs_n, dp_n, scan_done);
        end else begin
            $display("%s: outputs forced idle without a clock edge", name);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] rand_code();
        case ($urandom_range(3))
            0: return 7'($urandom_range(127));
            1: return 7'h00;
            2: return 7'($urandom_range(15));
            default: return 7'h20 | 7'($urandom_range(31));
        endcase
    endfunction

    initial begin
        logic [7*NDIG-1:0] rd;
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(40);
        do_load({7'h23, 7'h10, 7'h0E, 7'h0A}, 4'b0000, 1'b0);
        run(40);
        do_load({7'h00, 7'h00, 7'h05, 7'h00}, 4'b0000, 1'b1);
        run(20);
        do_load({7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000, 1'b1);
        run(20);
        do_load({7'h07, 7'h12, 7'h3C, 7'h09}, 4'b0001, 1'b0);
        run(5 * SCAN);
        // Load coinciding with the tick that enters digit 1, then a mid-slot load.
        wait_pos(0, DIV - 1, "load_on_tick");
        do_load({7'h01, 7'h02, 7'h2B, 7'h04}, 4'b0000, 1'b0);
        run(2);
        wait_pos(2, 1, "load_mid_slot");
        do_load({7'h0F, 7'h0D, 7'h06, 7'h08}, 4'b0000, 1'b0);
        run(10);
        wait_pos(2, 2, "async_reset_pos");
        async_reset_check("async_reset_mid_slot");
        run(2 * SCAN);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) begin
                for (int i = 0; i < NDIG; i++) rd[7*i +: 7] = rand_code();
                do_load(rd, NDIG'($urandom), 1'($urandom));
            end else if ($urandom_range(499) == 0) begin
                async_reset_check("async_reset_random");
            end else begin
                @(negedge clk);
            end
        end
        run(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
